// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state type,
// default parameter values and small elaboration-time helpers.
package pll_sup_pkg;

  localparam int DEF_NUM_RST             = 3;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_FILTER_CYCLES  = 256;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_RST_STAGGER_CYCLES  = 8;
  localparam int DEF_MAX_RETRIES         = 4;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAULT
  } pll_sup_state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so sync_q takes the previous meta_q, keeping two real stages.
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, waits for a filtered lock,
// then releases downstream reset channels one by one. Lock loss or a lock
// timeout triggers a retry; too many failed attempts latch FAULT.
// Optional feature: define PLL_SUP_LOSS_COUNT_EN to count lock-loss events
// on loss_cnt; otherwise loss_cnt is constant zero.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_RST             = DEF_NUM_RST,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int RST_STAGGER_CYCLES  = DEF_RST_STAGGER_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               lock,
  output logic               pll_reset,
  output logic [NUM_RST-1:0] rst_out,
  output logic               locked_stable,
  output logic               fault,
  output logic [3:0]         retry_cnt,
  output logic [7:0]         loss_cnt
);

  // Cycle offset of the last channel release, relative to RELEASE entry.
  localparam int REL_SPAN = (NUM_RST - 1) * RST_STAGGER_CYCLES;
  localparam int PR_W     = cnt_width(PLL_RST_CYCLES);
  localparam int TO_W     = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int REL_W    = cnt_width(REL_SPAN + 1);
  // One phase counter is shared by PLL_RST, WAIT_LOCK and RELEASE.
  localparam int CNT_W    = max_int(PR_W, max_int(TO_W, REL_W));
  localparam int FLT_W    = cnt_width(LOCK_FILTER_CYCLES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clkin),
    .rst_i (reset),
    .d_i   (lock),
    .q_o   (lock_s)
  );

  pll_sup_state_e     state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FLT_W-1:0]   flt_q;
  logic               pll_reset_q;
  logic [NUM_RST-1:0] rst_q;
  logic               locked_q;
  logic               fault_q;
  logic [3:0]         retry_q;

  logic [CNT_W-1:0]   cnt_inc;
  logic [3:0]         retry_d;
  logic               retry_exhausted;
  logic               flt_done;
  logic               timeout;

  assign cnt_inc         = cnt_q + CNT_W'(1);
  // Saturating increment: the attempt counter must never wrap to zero.
  assign retry_d         = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
  assign retry_exhausted = (retry_d == 4'(MAX_RETRIES));
  assign flt_done        = lock_s && (flt_q == FLT_W'(LOCK_FILTER_CYCLES - 1));
  assign timeout         = (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));

  // Supervisor FSM with all outputs registered alongside the state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      flt_q       <= '0;
      pll_reset_q <= 1'b1;
      rst_q       <= '1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            flt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        WAIT_LOCK: begin
          // Filter completion is tested first so it wins over a coincident timeout.
          if (flt_done) begin
            cnt_q <= '0;
            flt_q <= '0;
            if (REL_SPAN == 0) begin
              rst_q    <= '0;
              state_q  <= RUN;
              locked_q <= 1'b1;
              retry_q  <= '0;
            end else begin
              rst_q[0] <= 1'b0;
              state_q  <= RELEASE;
            end
          end else if (timeout) begin
            cnt_q   <= '0;
            flt_q   <= '0;
            retry_q <= retry_d;
            if (retry_exhausted) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q     <= PLL_RST;
              pll_reset_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
            flt_q <= lock_s ? flt_q + FLT_W'(1) : '0;
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            rst_q   <= '1;
            cnt_q   <= '0;
            retry_q <= retry_d;
            if (retry_exhausted) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q     <= PLL_RST;
              pll_reset_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
            for (int i = 1; i < NUM_RST; i++) begin
              if (cnt_inc == CNT_W'(i * RST_STAGGER_CYCLES)) rst_q[i] <= 1'b0;
            end
            if (cnt_inc == CNT_W'(REL_SPAN)) begin
              state_q  <= RUN;
              locked_q <= 1'b1;
              retry_q  <= '0;
            end
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_q       <= '1;
            locked_q    <= 1'b0;
            retry_q     <= '0;
          end
        end

        FAULT: begin
          // Terminal until reset; all registered outputs hold.
        end

        default: begin
          state_q     <= PLL_RST;
          cnt_q       <= '0;
          flt_q       <= '0;
          pll_reset_q <= 1'b1;
          rst_q       <= '1;
          locked_q    <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset     = pll_reset_q;
  assign rst_out       = rst_q;
  assign locked_stable = locked_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  assign loss_evt = !lock_s && ((state_q == RELEASE) || (state_q == RUN));

  // Count lock-loss events in RELEASE or RUN, saturating at 255.
  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with small parameters.
module tb_pll_lock_supervisor;

  localparam int NUM_RST             = 3;
  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_FILTER_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 64;
  localparam int RST_STAGGER_CYCLES  = 3;
  localparam int MAX_RETRIES         = 2;

`ifdef PLL_SUP_LOSS_COUNT_EN
  localparam logic [7:0] LOSS_ONE = 8'd1;
`else
  localparam logic [7:0] LOSS_ONE = 8'd0;
`endif

  logic               clkin = 1'b0;
  logic               reset = 1'b1;
  logic               lock  = 1'b0;
  logic               pll_reset;
  logic [NUM_RST-1:0] rst_out;
  logic               locked_stable;
  logic               fault;
  logic [3:0]         retry_cnt;
  logic [7:0]         loss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .NUM_RST             (NUM_RST),
    .PLL_RST_CYCLES      (PLL_RST_CYCLES),
    .LOCK_FILTER_CYCLES  (LOCK_FILTER_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .RST_STAGGER_CYCLES  (RST_STAGGER_CYCLES),
    .MAX_RETRIES         (MAX_RETRIES)
  ) dut (
    .clkin         (clkin),
    .reset         (reset),
    .lock          (lock),
    .pll_reset     (pll_reset),
    .rst_out       (rst_out),
    .locked_stable (locked_stable),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .loss_cnt      (loss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  // Hold reset for n edges; cycle 0 is the sample right after the last reset edge.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pll_reset"}, 32'(pll_reset), 32'd1);
    check({tag, " rst_out"}, 32'(rst_out), 32'h7);
    check({tag, " locked"}, 32'(locked_stable), 32'd0);
    check({tag, " fault"}, 32'(fault), 32'd0);
    check({tag, " retry"}, 32'(retry_cnt), 32'd0);
    check({tag, " loss"}, 32'(loss_cnt), 32'd0);
  endtask

  // Start-up with lock already high: pll_reset for cycles 0..3, WAIT_LOCK from 4,
  // filter done at 12 (rst_out 110), 15 (100), 18 (000 and locked_stable).
  task automatic check_startup(input string tag);
    logic [2:0] exp_rst;
    for (int k = 0; k < 20; k++) begin
      goto(k);
      if (k < 12)      exp_rst = 3'b111;
      else if (k < 15) exp_rst = 3'b110;
      else if (k < 18) exp_rst = 3'b100;
      else             exp_rst = 3'b000;
      check($sformatf("%s pll_reset k%0d", tag, k), 32'(pll_reset), 32'(k < 4));
      check($sformatf("%s rst_out k%0d", tag, k), 32'(rst_out), 32'(exp_rst));
      check($sformatf("%s locked k%0d", tag, k), 32'(locked_stable), 32'(k >= 18));
    end
    check({tag, " retry in run"}, 32'(retry_cnt), 32'd0);
    check({tag, " fault in run"}, 32'(fault), 32'd0);
  endtask

  initial begin
    // ---- Start-up, run loss, reset during release ----
    lock = 1'b1;
    apply_reset(3);
    check_reset_state("A reset");
    check_startup("A start");

    lock = 1'b0;                  // at cycle 19; lock_s falls at 21
    cyc = 0;
    goto(2);
    check("A loss before", 32'(rst_out), 32'h0);
    check("A loss locked before", 32'(locked_stable), 32'd1);
    goto(3);
    check("A loss rst_out", 32'(rst_out), 32'h7);
    check("A loss locked", 32'(locked_stable), 32'd0);
    check("A loss pll_reset", 32'(pll_reset), 32'd1);
    check("A loss retry", 32'(retry_cnt), 32'd0);
    check("A loss cnt", 32'(loss_cnt), 32'(LOSS_ONE));
    lock = 1'b1;
    goto(6);
    check("A loss pll_reset c6", 32'(pll_reset), 32'd1);
    goto(7);
    check("A loss pll_reset c7", 32'(pll_reset), 32'd0);
    goto(14);
    check("A relock c14", 32'(rst_out), 32'h7);
    goto(15);
    check("A relock c15", 32'(rst_out), 32'h6);
    goto(18);
    check("A relock c18", 32'(rst_out), 32'h4);

    apply_reset(1);
    check_reset_state("A mid-release reset");
    check_startup("A restart");

    // ---- Lock never arrives: two timeouts then FAULT ----
    lock = 1'b0;
    apply_reset(2);
    check_reset_state("B reset");
    goto(67);
    check("B pre-timeout retry", 32'(retry_cnt), 32'd0);
    check("B pre-timeout pll", 32'(pll_reset), 32'd0);
    goto(68);
    check("B timeout1 retry", 32'(retry_cnt), 32'd1);
    check("B timeout1 pll", 32'(pll_reset), 32'd1);
    check("B timeout1 fault", 32'(fault), 32'd0);
    goto(71);
    check("B retry pll c71", 32'(pll_reset), 32'd1);
    goto(72);
    check("B retry pll c72", 32'(pll_reset), 32'd0);
    goto(135);
    check("B pre-timeout2 fault", 32'(fault), 32'd0);
    check("B pre-timeout2 retry", 32'(retry_cnt), 32'd1);
    goto(136);
    check("B fault", 32'(fault), 32'd1);
    check("B fault retry", 32'(retry_cnt), 32'd2);
    check("B fault rst_out", 32'(rst_out), 32'h7);
    check("B fault pll", 32'(pll_reset), 32'd0);
    lock = 1'b1;
    goto(170);
    check("B fault held", 32'(fault), 32'd1);
    check("B fault held rst_out", 32'(rst_out), 32'h7);
    check("B fault held pll", 32'(pll_reset), 32'd0);
    check("B fault held locked", 32'(locked_stable), 32'd0);
    apply_reset(1);
    check_reset_state("B reset from fault");

    // ---- Filter restart, release loss, then fault ----
    lock = 1'b0;
    apply_reset(2);
    goto(4);
    lock = 1'b1;                  // lock_s high 7 cycles seen by WAIT_LOCK
    goto(11);
    lock = 1'b0;
    goto(12);
    lock = 1'b1;
    goto(14);
    check("C filter 7 not enough", 32'(rst_out), 32'h7);
    goto(21);
    check("C filter c21", 32'(rst_out), 32'h7);
    goto(22);
    check("C release entry", 32'(rst_out), 32'h6);
    check("C release pll", 32'(pll_reset), 32'd0);
    goto(23);
    lock = 1'b0;
    goto(25);
    check("C release c25", 32'(rst_out), 32'h4);
    goto(26);
    check("C rel loss rst_out", 32'(rst_out), 32'h7);
    check("C rel loss retry", 32'(retry_cnt), 32'd1);
    check("C rel loss pll", 32'(pll_reset), 32'd1);
    check("C rel loss locked", 32'(locked_stable), 32'd0);
    check("C rel loss cnt", 32'(loss_cnt), 32'(LOSS_ONE));
    goto(29);
    check("C pll c29", 32'(pll_reset), 32'd1);
    goto(30);
    check("C pll c30", 32'(pll_reset), 32'd0);
    goto(93);
    check("C pre-fault", 32'(fault), 32'd0);
    goto(94);
    check("C fault", 32'(fault), 32'd1);
    check("C fault retry", 32'(retry_cnt), 32'd2);
    check("C fault rst_out", 32'(rst_out), 32'h7);
    check("C fault pll", 32'(pll_reset), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
